// File: rtl/atm_pkg.sv
// Shared keypad definitions: default widths, digit limits and the entry state enum,
// plus small helpers for decoding the ten digit keys.
package atm_pkg;

    localparam int P_WIDTH_DEF     = 16;
    localparam int B_WIDTH_DEF     = 20;
    localparam int PWD_DIGITS      = 4;
    localparam int CONV_CYCLES_DEF = 6;
    localparam int NUM_KEYS        = 13;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_CONVERT
    } kp_state_e;

    function automatic logic [3:0] count_keys(input logic [9:0] k);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'b000, k[i]};
        end
        return n;
    endfunction

    // Only meaningful when exactly one bit of k is set.
    function automatic logic [3:0] key_to_bcd(input logic [9:0] k);
        logic [3:0] d;
        d = '0;
        for (int i = 0; i < 10; i++) begin
            if (k[i]) d = 4'(i);
        end
        return d;
    endfunction

endpackage

// File: rtl/key_edge.sv
// Rising-edge detector for the keypad keys. Edges are suppressed on the first
// cycle after reset so that keys held through reset release never register.
module key_edge
    import atm_pkg::*;
#(
    parameter int N_KEYS = NUM_KEYS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] keys_i,
    output logic [N_KEYS-1:0] edges_o
);

    logic [N_KEYS-1:0] level_q;
    logic              armed_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= '0;
            armed_q <= 1'b0;
        end else begin
            level_q <= keys_i;
            armed_q <= 1'b1;
        end
    end

    assign edges_o = armed_q ? (keys_i & ~level_q) : '0;

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry controller: collects BCD digits for a 4-digit password or a decimal
// amount, supports correct/cancel, and converts amounts to binary one digit per cycle.
module keypad_entry
    import atm_pkg::*;
#(
    parameter int P_WIDTH     = P_WIDTH_DEF,
    parameter int B_WIDTH     = B_WIDTH_DEF,
    parameter int CONV_CYCLES = CONV_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9:0]         buttons,
    input  logic               enter_button,
    input  logic               cancel_button,
    input  logic               correct_button,
    input  logic               amount_mode,
    output logic [P_WIDTH-1:0] in_password,
    output logic [B_WIDTH-1:0] entry_value,
    output logic               entry_valid,
    output logic               cancel_pulse,
    output logic               key_error,
    output logic [2:0]         digit_count
);

    localparam int ST_W = CONV_CYCLES * 4;

    logic [NUM_KEYS-1:0] key_lvl;
    logic [NUM_KEYS-1:0] key_edges;

    assign key_lvl = {cancel_button, correct_button, enter_button, buttons};

    key_edge #(.N_KEYS(NUM_KEYS)) u_key_edge (
        .clk    (clk),
        .rst    (rst),
        .keys_i (key_lvl),
        .edges_o(key_edges)
    );

    kp_state_e          state_q;
    logic [ST_W-1:0]    store_q;
    logic [B_WIDTH-1:0] acc_q;
    logic [2:0]         cnt_q;
    logic [2:0]         conv_q;
    logic               mode_q;
    logic [P_WIDTH-1:0] pwd_q;
    logic [B_WIDTH-1:0] value_q;
    logic               valid_q;
    logic               cancel_q;
    logic               error_q;

    logic [9:0]         dig_e;
    logic               enter_e, correct_e, cancel_e;
    logic               any_dig, one_dig;
    logic [3:0]         dig_bcd;
    logic [2:0]         digit_limit;
    logic [3:0]         top_nib;
    logic [B_WIDTH-1:0] acc_d;

    assign dig_e       = key_edges[9:0];
    assign enter_e     = key_edges[10];
    assign correct_e   = key_edges[11];
    assign cancel_e    = key_edges[12];
    assign any_dig     = |dig_e;
    assign one_dig     = (count_keys(dig_e) == 4'd1);
    assign dig_bcd     = key_to_bcd(dig_e);
    assign digit_limit = mode_q ? 3'(CONV_CYCLES) : 3'(PWD_DIGITS);

    // Digits sit right-aligned in the store, so the top nibble supplies the
    // leading zero padding before the real digits arrive MS first.
    assign top_nib = store_q[ST_W-1 -: 4];
    assign acc_d   = (acc_q * B_WIDTH'(10)) + B_WIDTH'(top_nib);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            store_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            conv_q   <= '0;
            mode_q   <= 1'b0;
            pwd_q    <= '0;
            value_q  <= '0;
            valid_q  <= 1'b0;
            cancel_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            valid_q  <= 1'b0;
            cancel_q <= 1'b0;
            error_q  <= 1'b0;
            if (cancel_e) begin
                state_q  <= ST_IDLE;
                store_q  <= '0;
                acc_q    <= '0;
                cnt_q    <= '0;
                conv_q   <= '0;
                cancel_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (enter_e || correct_e) begin
                            error_q <= 1'b1;
                        end else if (any_dig) begin
                            if (!one_dig) begin
                                error_q <= 1'b1;
                            end else begin
                                store_q <= {store_q[ST_W-5:0], dig_bcd};
                                cnt_q   <= 3'd1;
                                mode_q  <= amount_mode;
                                state_q <= ST_ENTRY;
                            end
                        end
                    end
                    ST_ENTRY: begin
                        if (enter_e) begin
                            if (mode_q) begin
                                acc_q   <= '0;
                                conv_q  <= '0;
                                state_q <= ST_CONVERT;
                            end else if (cnt_q == 3'(PWD_DIGITS)) begin
                                pwd_q   <= store_q[P_WIDTH-1:0];
                                valid_q <= 1'b1;
                                store_q <= '0;
                                cnt_q   <= '0;
                                state_q <= ST_IDLE;
                            end else begin
                                error_q <= 1'b1;
                            end
                        end else if (correct_e) begin
                            store_q <= {4'h0, store_q[ST_W-1:4]};
                            cnt_q   <= cnt_q - 3'd1;
                            if (cnt_q == 3'd1) state_q <= ST_IDLE;
                        end else if (any_dig) begin
                            if (!one_dig || cnt_q >= digit_limit) begin
                                error_q <= 1'b1;
                            end else begin
                                store_q <= {store_q[ST_W-5:0], dig_bcd};
                                cnt_q   <= cnt_q + 3'd1;
                            end
                        end
                    end
                    ST_CONVERT: begin
                        acc_q   <= acc_d;
                        store_q <= {store_q[ST_W-5:0], 4'h0};
                        conv_q  <= conv_q + 3'd1;
                        if (conv_q == 3'(CONV_CYCLES - 1)) begin
                            value_q <= acc_d;
                            valid_q <= 1'b1;
                            store_q <= '0;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            conv_q  <= '0;
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign in_password  = pwd_q;
    assign entry_value  = value_q;
    assign entry_valid  = valid_q;
    assign cancel_pulse = cancel_q;
    assign key_error    = error_q;
    assign digit_count  = cnt_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: password and amount entry, correction,
// cancel, error pulses, conversion latency and reset behaviour.
module tb_keypad_entry;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  buttons;
    logic        enter_button, cancel_button, correct_button, amount_mode;
    logic [15:0] in_password;
    logic [19:0] entry_value;
    logic        entry_valid, cancel_pulse, key_error;
    logic [2:0]  digit_count;

    int checks   = 0;
    int failures = 0;

    logic        s_valid, s_cancel, s_err;
    logic [2:0]  s_cnt;

    localparam logic [12:0] ENT = 13'h0400;
    localparam logic [12:0] COR = 13'h0800;
    localparam logic [12:0] CAN = 13'h1000;

    keypad_entry dut (
        .clk           (clk),
        .rst           (rst),
        .buttons       (buttons),
        .enter_button  (enter_button),
        .cancel_button (cancel_button),
        .correct_button(correct_button),
        .amount_mode   (amount_mode),
        .in_password   (in_password),
        .entry_value   (entry_value),
        .entry_valid   (entry_valid),
        .cancel_pulse  (cancel_pulse),
        .key_error     (key_error),
        .digit_count   (digit_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] dk(input int n);
        logic [12:0] one;
        one = 13'd1;
        return one << n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [12:0] k);
        buttons        = k[9:0];
        enter_button   = k[10];
        correct_button = k[11];
        cancel_button  = k[12];
    endtask

    // Press for one cycle, snapshot the registered reaction, then release for one cycle.
    task automatic hit(input logic [12:0] k);
        drive(k);
        tick();
        s_valid  = entry_valid;
        s_cancel = cancel_pulse;
        s_err    = key_error;
        s_cnt    = digit_count;
        drive(13'h0);
        tick();
    endtask

    task automatic wait_valid(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            seen = entry_valid;
        end
        check_val(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        amount_mode = 1'b0;
        drive(13'h0);
        buttons[3] = 1'b1;
        repeat (3) tick();
        check_val("rst_pwd",    32'(in_password),  32'h0);
        check_val("rst_value",  32'(entry_value),  32'd0);
        check_val("rst_valid",  32'(entry_valid),  32'd0);
        check_val("rst_cancel", 32'(cancel_pulse), 32'd0);
        check_val("rst_err",    32'(key_error),    32'd0);
        check_val("rst_cnt",    32'(digit_count),  32'd0);
        rst = 1'b1;
        tick();
        tick();
        check_val("held_key_cnt", 32'(digit_count), 32'd0);
        drive(13'h0);
        tick();

        // Password 1234
        hit(dk(1)); check_val("pw_cnt1", 32'(s_cnt), 32'd1);
        hit(dk(2));
        hit(dk(3));
        hit(dk(4)); check_val("pw_cnt4", 32'(s_cnt), 32'd4);
        hit(ENT);
        check_val("pw_valid", 32'(s_valid), 32'd1);
        check_val("pw_value", 32'(in_password), 32'h1234);
        check_val("pw_cnt0", 32'(s_cnt), 32'd0);
        check_val("pw_valid_fall", 32'(entry_valid), 32'd0);

        // Fifth password digit rejected
        hit(dk(5)); hit(dk(6)); hit(dk(7)); hit(dk(8));
        hit(dk(9));
        check_val("pw5_err", 32'(s_err), 32'd1);
        check_val("pw5_cnt", 32'(s_cnt), 32'd4);
        hit(ENT);
        check_val("pw5_valid", 32'(s_valid), 32'd1);
        check_val("pw5_value", 32'(in_password), 32'h5678);

        // Enter + digit together with 3 digits, then cancel and idle errors
        hit(dk(1)); hit(dk(2)); hit(dk(3));
        hit(ENT | dk(5));
        check_val("short_err", 32'(s_err), 32'd1);
        check_val("short_cnt", 32'(s_cnt), 32'd3);
        check_val("short_novalid", 32'(s_valid), 32'd0);
        hit(CAN);
        check_val("can_pulse", 32'(s_cancel), 32'd1);
        check_val("can_cnt", 32'(s_cnt), 32'd0);
        check_val("can_pwd_kept", 32'(in_password), 32'h5678);
        hit(ENT);  check_val("idle_enter_err", 32'(s_err), 32'd1);
        hit(COR);  check_val("idle_corr_err", 32'(s_err), 32'd1);
        hit(dk(1) | dk(2));
        check_val("multi_err", 32'(s_err), 32'd1);
        check_val("multi_cnt", 32'(s_cnt), 32'd0);

        // Amount 1500 with exact conversion latency
        amount_mode = 1'b1;
        hit(dk(1)); hit(dk(5)); hit(dk(0)); hit(dk(0));
        check_val("amt_cnt4", 32'(s_cnt), 32'd4);
        drive(ENT);
        tick();
        check_val("amt_valid_c0", 32'(entry_valid), 32'd0);
        drive(13'h0);
        for (int i = 1; i <= 7; i++) begin
            tick();
            check_val($sformatf("amt_valid_c%0d", i), 32'(entry_valid), (i == 6) ? 32'd1 : 32'd0);
            if (i == 6) check_val("amt_value", 32'(entry_value), 32'd1500);
        end

        // Amount 27, correct, 9 -> 29
        hit(dk(2)); check_val("cor_cnt_a", 32'(s_cnt), 32'd1);
        hit(dk(7)); check_val("cor_cnt_b", 32'(s_cnt), 32'd2);
        hit(COR);   check_val("cor_cnt_c", 32'(s_cnt), 32'd1);
        hit(dk(9)); check_val("cor_cnt_d", 32'(s_cnt), 32'd2);
        drive(ENT);
        tick();
        drive(13'h0);
        wait_valid("cor_valid_seen");
        check_val("cor_value", 32'(entry_value), 32'd29);

        // Cancel in the third conversion cycle
        tick();
        hit(dk(9)); hit(dk(9));
        drive(ENT);
        tick();
        drive(13'h0);
        tick();
        tick();
        drive(CAN);
        tick();
        check_val("cconv_cancel", 32'(cancel_pulse), 32'd1);
        check_val("cconv_valid", 32'(entry_valid), 32'd0);
        drive(13'h0);
        s_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            s_valid = s_valid | entry_valid;
        end
        check_val("cconv_no_valid", 32'(s_valid), 32'd0);
        check_val("cconv_value_kept", 32'(entry_value), 32'd29);
        check_val("cconv_cnt", 32'(digit_count), 32'd0);

        // Mode switch after first digit is ignored
        hit(dk(4));
        amount_mode = 1'b0;
        hit(dk(2));
        drive(ENT);
        tick();
        check_val("mode_no_pw_valid", 32'(entry_valid), 32'd0);
        drive(13'h0);
        wait_valid("mode_valid_seen");
        check_val("mode_value", 32'(entry_value), 32'd42);
        check_val("mode_pwd_kept", 32'(in_password), 32'h5678);

        // Reset mid-entry
        tick();
        hit(dk(1)); hit(dk(2));
        rst = 1'b0;
        #1;
        check_val("mid_rst_cnt", 32'(digit_count), 32'd0);
        check_val("mid_rst_pwd", 32'(in_password), 32'h0);
        check_val("mid_rst_value", 32'(entry_value), 32'd0);
        check_val("mid_rst_err", 32'(key_error), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
